// File: rtl/mux8_arb_pkg.sv
// Shared types and sizes for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;
    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/mux8_arbiter_if.sv
// Request/grant bundle between the sources/consumer side (master) and the arbiter (slave).
interface mux8_arbiter_if;
    import mux8_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             out_ready;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] SelMux8;
    logic             out_valid;

    modport master (
        output req,
        output out_ready,
        input  grant,
        input  SelMux8,
        input  out_valid
    );

    modport slave (
        input  req,
        input  out_ready,
        output grant,
        output SelMux8,
        output out_valid
    );
endinterface

// File: rtl/mux8_arbiter_rr_pick.sv
// Combinational round-robin picker: first unmasked request at ptr, ptr+1, ... modulo 8.
module rr_pick
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [N_REQ-1:0] w_cand;
    logic [SEL_W-1:0] w_j;

    assign w_cand = req & ~mask;

    // Scan from the farthest offset down so the nearest candidate to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_j = ptr + i[SEL_W-1:0];
            if (w_cand[w_j]) begin
                found = 1'b1;
                idx   = w_j;
            end
        end
    end
endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter driving the select of an 8-input mux, with a per-grant transfer cap.
module mux8_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           reset,
    mux8_arbiter_if.slave  bus
);
    arb_state_e        r_state, w_state_n;
    logic [SEL_W-1:0]  r_sel, w_sel_n;
    logic [SEL_W-1:0]  r_rr_ptr, w_rr_ptr_n;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_n;

    logic [N_REQ-1:0]  w_owner_oh;
    logic              w_others;
    logic              w_xfer;
    logic [HOLD_W-1:0] w_cnt_inc;
    logic              w_at_max;
    logic              w_release;
    logic [SEL_W-1:0]  w_pick_ptr;
    logic [N_REQ-1:0]  w_pick_mask;
    logic              w_found;
    logic [SEL_W-1:0]  w_idx;

    assign w_owner_oh = N_REQ'(1) << r_sel;
    assign w_others   = |(bus.req & ~w_owner_oh);
    assign w_xfer     = (r_state == GRANT) && bus.out_ready;
    assign w_cnt_inc  = r_hold_cnt + {{(HOLD_W-1){1'b0}}, w_xfer};
    assign w_at_max   = w_xfer && (w_cnt_inc == HOLD_W'(MAX_HOLD));
    // An owner drop coinciding with the cap is still a single release.
    assign w_release  = (r_state == GRANT) &&
                        (!bus.req[r_sel] || (w_at_max && w_others));

    // On release the search starts just past the owner and skips it.
    assign w_pick_ptr  = w_release ? r_sel + SEL_W'(1) : r_rr_ptr;
    assign w_pick_mask = w_release ? w_owner_oh : '0;

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (w_pick_ptr),
        .mask  (w_pick_mask),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_state_n    = r_state;
        w_sel_n      = r_sel;
        w_rr_ptr_n   = r_rr_ptr;
        w_hold_cnt_n = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n    = GRANT;
                    w_sel_n      = w_idx;
                    w_hold_cnt_n = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_rr_ptr_n   = r_sel + SEL_W'(1);
                    w_hold_cnt_n = '0;
                    if (w_found) w_sel_n   = w_idx;
                    else         w_state_n = IDLE;
                end else if (w_at_max) begin
                    w_hold_cnt_n = '0;
                end else begin
                    w_hold_cnt_n = w_cnt_inc;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_sel      <= w_sel_n;
            r_rr_ptr   <= w_rr_ptr_n;
            r_hold_cnt <= w_hold_cnt_n;
        end
    end

    assign bus.out_valid = (r_state == GRANT);
    assign bus.grant     = (r_state == GRANT) ? w_owner_oh : '0;
    assign bus.SelMux8   = r_sel;
endmodule

// File: doc/mux8_arbiter.md
MUX8_ARBITER -- requirements
Module: mux8_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum number of transfers per grant while other requests are pending (legal range 1..255).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset: input, 1 bit, synchronous active-high reset.
REQ-005 Port req: input, 8 bits, bit i is the request from source i (source i feeds mux input i, a..h = 0..7).
REQ-006 Port out_ready: input, 1 bit, the downstream consumer accepts the muxed word this cycle.
REQ-007 Port grant: output, 8 bits, one-hot current owner, all-zero when idle.
REQ-008 Port SelMux8: output, 3 bits, the binary index of the owner; it drives the 8-input 64-bit mux select.
REQ-009 Port out_valid: output, 1 bit, the mux output carries a granted source's word.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 A transfer SHALL occur in every cycle where out_valid=1 and out_ready=1.
REQ-012 The round-robin pointer rr_ptr (3 bits) SHALL mark the highest-priority source; the winner is the first set req bit at index rr_ptr, rr_ptr+1, ... modulo 8.
REQ-013 In IDLE with req!=0, the FSM SHALL enter GRANT next cycle, with grant/SelMux8 set to the winner; latency from req to grant is 1 cycle.
REQ-014 In IDLE with req==0, all outputs SHALL hold: grant=0, out_valid=0, SelMux8 at its last value.
REQ-015 In GRANT, hold_cnt (8 bits) SHALL increment on each transfer and clear on every owner change.
REQ-016 Release SHALL occur when req[owner]=0, or when the count reaches MAX_HOLD (including the current cycle's transfer) and another req bit is set.
REQ-017 On release, rr_ptr SHALL become (owner+1) mod 8 on the next edge, wrapping 7->0.
REQ-018 On release, the block SHALL re-arbitrate in the same cycle, excluding the releasing owner; a new winner is granted on the next edge with no idle bubble.
REQ-019 On release with no other request pending, the FSM SHALL go to IDLE.
REQ-020 If the count reaches MAX_HOLD with no other request pending, the owner SHALL keep the grant, hold_cnt SHALL restart at 0, and rr_ptr SHALL be unchanged.
REQ-021 If req[owner] drops in the same cycle that MAX_HOLD is reached, this SHALL count as a single release.
REQ-022 While out_ready=0, hold_cnt SHALL freeze and the grant SHALL stay, unless req[owner] drops.
REQ-023 out_valid SHALL equal 1 exactly when state is GRANT.
REQ-024 grant SHALL always be one-hot in GRANT and zero in IDLE.
REQ-025 SelMux8 SHALL always equal the encode of grant while in GRANT.

Reset
REQ-026 Reset SHALL set state=IDLE, grant=0, SelMux8=0, out_valid=0, rr_ptr=0 and hold_cnt=0 on the edge it is sampled.
REQ-027 Reset asserted mid-grant SHALL abort the grant; outputs read idle from the next cycle, and the held request is re-arbitrated from rr_ptr=0 after reset deasserts.

Structure
REQ-028 Package mux8_arb_pkg SHALL hold the state enum (IDLE, GRANT), N_REQ=8, SEL_W=3 and HOLD_W=8.
REQ-029 Sub-module rr_pick SHALL be combinational: inputs req[7:0], ptr[2:0] and mask[7:0]; outputs found and idx[2:0].
REQ-030 All registered state SHALL reside in mux8_arbiter.

Verification
REQ-031 Reset check: reset=1 with req=8'hFF -> grant=0, out_valid=0, SelMux8=0; deassert reset -> next cycle grant=8'h01, SelMux8=0.
REQ-032 Rotation: req=8'h81 held, out_ready=1, MAX_HOLD=4 -> 4 transfers to source 0, then source 7 (SelMux8=7) with no bubble, then 4 transfers, then wrap back to source 0.
REQ-033 Early release: source 3 owns, req[3] drops after 2 transfers, req[5]=1 -> next cycle grant=8'h20, rr_ptr=4.
REQ-034 Backpressure: source 2 owns, out_ready=0 for 10 cycles, req=8'h0C -> grant stays 8'h04 and hold_cnt frozen; after out_ready=1, 4 transfers occur, then source 3 is granted.
REQ-035 Sole requester: req=8'h10 only, 12 transfers -> grant remains 8'h10 throughout, hold_cnt wraps at 4, out_valid continuously 1.
REQ-036 Reset mid-grant: reset pulsed while source 6 owns -> idle next cycle; after release, req=8'h40 re-granted with SelMux8=6, and an assertion confirms grant is one-hot/zero every cycle.
